// File: rtl/usbt_pkt_drain_if.sv
// FIFO read side and packet output side of the packet drain, bundled as one interface.
// slave: the drain itself (pops the FIFO, drives packet beats); master: the FIFO/sink environment.
interface usbt_pkt_drain_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int COD_ENDP_WIDTH = 6
);
  logic                      fifo_read_ready;
  logic                      fifo_read_command;
  logic                      fifo_eop;
  logic                      fifo_error;
  logic                      fifo_entry_type;
  logic [1:0]                fifo_d_width;
  logic [COD_ENDP_WIDTH-1:0] fifo_endp_entry;
  logic [DATA_WIDTH-1:0]     fifo_data;

  logic                      pkt_valid;
  logic                      pkt_ready;
  logic                      pkt_sop;
  logic                      pkt_eop;
  logic                      pkt_err;
  logic [1:0]                pkt_bytes;
  logic [DATA_WIDTH-1:0]     pkt_data;
  logic [COD_ENDP_WIDTH-1:0] pkt_endp;

  modport master (
    output fifo_read_ready, fifo_eop, fifo_error, fifo_entry_type,
    output fifo_d_width, fifo_endp_entry, fifo_data,
    input  fifo_read_command,
    input  pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_bytes, pkt_data, pkt_endp,
    output pkt_ready
  );

  modport slave (
    input  fifo_read_ready, fifo_eop, fifo_error, fifo_entry_type,
    input  fifo_d_width, fifo_endp_entry, fifo_data,
    output fifo_read_command,
    output pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_bytes, pkt_data, pkt_endp,
    input  pkt_ready
  );
endinterface

// File: rtl/usbt_pkt_drain.sv
// Drains packets from a show-ahead FIFO into a header beat plus one beat per word (latency 1);
// holds its output register under pkt_ready=0. Optional stats counters: define USBT_PKT_DRAIN_STATS_EN.
module usbt_pkt_drain #(
  parameter int DATA_WIDTH     = 32,
  parameter int COD_ENDP_WIDTH = 6,
  parameter int USB_LEN_WIDTH  = 12,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     drain_en,
  input  logic [USB_LEN_WIDTH-1:0] max_usb_pkt_len,
  usbt_pkt_drain_if.slave          bus,
  input  logic                     stats_clr,
  output logic [CNT_WIDTH-1:0]     pkt_cnt,
  output logic [CNT_WIDTH-1:0]     err_pkt_cnt,
  output logic                     busy
);

  localparam int BW = USB_LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                      r_vld;
  logic                      r_sop;
  logic                      r_eop;
  logic                      r_err;
  logic [1:0]                r_bytes;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [COD_ENDP_WIDTH-1:0] r_endp;
  logic [BW-1:0]             r_byte_cnt;

  logic                      w_out_free;
  logic                      w_pop;
  logic                      w_load;
  logic                      w_ld_sop;
  logic                      w_ld_eop;
  logic                      w_ld_err;
  logic [1:0]                w_ld_bytes;
  logic [DATA_WIDTH-1:0]     w_ld_data;
  logic [COD_ENDP_WIDTH-1:0] w_ld_endp;
  logic [DATA_WIDTH-1:0]     w_hdr_word;
  logic [2:0]                w_word_bytes;
  logic [BW:0]               w_cnt_sum;
  logic [BW-1:0]             w_cnt_sat;
  logic [BW-1:0]             w_byte_cnt_nxt;
  logic                      w_over;
  logic                      w_acc_eop;

  assign w_out_free = !r_vld || bus.pkt_ready;
  assign busy       = (r_state != S_IDLE);
  assign w_acc_eop  = r_vld && bus.pkt_ready && r_eop;

  // Byte accounting for the current head word; eop words carry a partial count, 0 encodes 4.
  always_comb begin
    w_word_bytes = 3'd4;
    if (bus.fifo_eop && (bus.fifo_d_width != 2'd0)) begin
      w_word_bytes = {1'b0, bus.fifo_d_width};
    end
    w_cnt_sum = {1'b0, r_byte_cnt} + {{(BW-2){1'b0}}, w_word_bytes};
    w_cnt_sat = w_cnt_sum[BW] ? {BW{1'b1}} : w_cnt_sum[BW-1:0];
    w_over    = (max_usb_pkt_len != '0) && !bus.fifo_eop &&
                (w_cnt_sat > {1'b0, max_usb_pkt_len});
  end

  always_comb begin
    w_hdr_word                             = '0;
    w_hdr_word[COD_ENDP_WIDTH-1:0]         = bus.fifo_endp_entry;
    w_hdr_word[COD_ENDP_WIDTH+1]           = bus.fifo_entry_type;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_pop          = 1'b0;
    w_load         = 1'b0;
    w_ld_sop       = 1'b0;
    w_ld_eop       = 1'b0;
    w_ld_err       = 1'b0;
    w_ld_bytes     = 2'd0;
    w_ld_data      = '0;
    w_ld_endp      = '0;
    unique case (r_state)
      S_IDLE: begin
        w_byte_cnt_nxt = '0;
        if (drain_en && bus.fifo_read_ready) begin
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        // Header is built from the head entry, which stays in the FIFO as the first data word.
        if (bus.fifo_read_ready && w_out_free) begin
          w_load      = 1'b1;
          w_ld_sop    = 1'b1;
          w_ld_data   = w_hdr_word;
          w_ld_endp   = bus.fifo_endp_entry;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.fifo_read_ready && w_out_free) begin
          w_pop          = 1'b1;
          w_load         = 1'b1;
          w_ld_data      = bus.fifo_data;
          w_ld_endp      = bus.fifo_endp_entry;
          w_byte_cnt_nxt = w_cnt_sat;
          if (bus.fifo_eop) begin
            w_ld_eop    = 1'b1;
            w_ld_err    = bus.fifo_error;
            w_ld_bytes  = bus.fifo_d_width;
            w_state_nxt = S_IDLE;
          end else if (w_over) begin
            w_ld_eop    = 1'b1;
            w_ld_err    = 1'b1;
            w_state_nxt = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (bus.fifo_read_ready) begin
          w_pop = 1'b1;
          if (bus.fifo_eop) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.fifo_read_command = w_pop && reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld   <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_err   <= 1'b0;
      r_bytes <= 2'd0;
      r_data  <= '0;
      r_endp  <= '0;
    end else if (w_load) begin
      r_vld   <= 1'b1;
      r_sop   <= w_ld_sop;
      r_eop   <= w_ld_eop;
      r_err   <= w_ld_err;
      r_bytes <= w_ld_bytes;
      r_data  <= w_ld_data;
      r_endp  <= w_ld_endp;
    end else if (bus.pkt_ready) begin
      r_vld   <= 1'b0;
    end
  end

  assign bus.pkt_valid = r_vld;
  assign bus.pkt_sop   = r_sop;
  assign bus.pkt_eop   = r_eop;
  assign bus.pkt_err   = r_err;
  assign bus.pkt_bytes = r_bytes;
  assign bus.pkt_data  = r_data;
  assign bus.pkt_endp  = r_endp;

`ifdef USBT_PKT_DRAIN_STATS_EN
  logic [CNT_WIDTH-1:0] r_pkt_cnt;
  logic [CNT_WIDTH-1:0] r_err_pkt_cnt;

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset_n || stats_clr) begin
      r_pkt_cnt     <= '0;
      r_err_pkt_cnt <= '0;
    end else if (w_acc_eop) begin
      if (r_pkt_cnt != {CNT_WIDTH{1'b1}}) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
      if (r_err && (r_err_pkt_cnt != {CNT_WIDTH{1'b1}})) begin
        r_err_pkt_cnt <= r_err_pkt_cnt + 1'b1;
      end
    end
  end

  assign pkt_cnt     = r_pkt_cnt;
  assign err_pkt_cnt = r_err_pkt_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = stats_clr ^ w_acc_eop;
  assign pkt_cnt        = '0;
  assign err_pkt_cnt    = '0;
`endif

endmodule

// File: tb/tb_usbt_pkt_drain.sv
// Randomized bench for usbt_pkt_drain: a packet-level model turns pushed FIFO packets into the
// expected beat stream and stats counts; a per-cycle monitor compares the DUT against it.
module tb_usbt_pkt_drain;
  localparam int DW = 32;
  localparam int EW = 6;
  localparam int LW = 12;
  localparam int CW = 16;
`ifdef USBT_PKT_DRAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          drain_en = 1'b0;
  logic          stats_clr = 1'b0;
  logic [LW-1:0] max_len = '0;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] err_pkt_cnt;
  logic          busy;

  usbt_pkt_drain_if #(.DATA_WIDTH(DW), .COD_ENDP_WIDTH(EW)) bus ();

  usbt_pkt_drain #(
    .DATA_WIDTH(DW), .COD_ENDP_WIDTH(EW), .USB_LEN_WIDTH(LW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .drain_en(drain_en), .max_usb_pkt_len(max_len),
    .bus(bus), .stats_clr(stats_clr), .pkt_cnt(pkt_cnt), .err_pkt_cnt(err_pkt_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic eop; logic err; logic typ; logic [1:0] dw; logic [EW-1:0] endp; logic [DW-1:0] data;
  } ent_t;
  typedef struct packed {
    logic sop; logic eop; logic err; logic [1:0] bytes; logic [EW-1:0] endp; logic [DW-1:0] data;
  } beat_t;

  ent_t  fq[$];
  beat_t exp_q[$];
  bit    exp_bchk[$];
  beat_t acc_log[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    rd_cnt = 0;
  int    acc_cnt = 0;
  int    exp_pc = 0;
  int    exp_ec = 0;
  int    rdy_mode = 0;
  bit    clr_rand = 1'b0;
  bit    pop_pend = 1'b0;
  bit    was_rst = 1'b0;
  bit    hold_vld = 1'b0;
  beat_t hold_beat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.sop = bus.pkt_sop; b.eop = bus.pkt_eop; b.err = bus.pkt_err; b.bytes = bus.pkt_bytes;
    b.endp = bus.pkt_endp; b.data = bus.pkt_data;
    return b;
  endfunction

  function automatic void add_exp(input beat_t b, input bit bchk);
    exp_q.push_back(b);
    exp_bchk.push_back(bchk);
  endfunction

  // Packet-level reference: header, then words until eop or until the byte limit is exceeded.
  function automatic void gen_stream(input ent_t s[$]);
    int i = 0;
    while (i < s.size()) begin
      beat_t b;
      int cnt = 0;
      bit dropping = 0;
      bit done = 0;
      b = '0;
      b.sop = 1'b1; b.endp = s[i].endp;
      b.data = DW'({s[i].typ, 1'b0, s[i].endp});
      add_exp(b, 1'b0);
      while (i < s.size() && !done) begin
        ent_t e = s[i];
        i++;
        b = '0; b.endp = e.endp; b.data = e.data;
        if (dropping) begin
          if (e.eop) done = 1;
        end else if (e.eop) begin
          b.eop = 1'b1; b.err = e.err; b.bytes = e.dw;
          add_exp(b, 1'b1);
          done = 1;
        end else begin
          cnt = (cnt + 4 > 8191) ? 8191 : cnt + 4;
          if (max_len != 0 && cnt > int'(max_len)) begin
            b.eop = 1'b1; b.err = 1'b1;
            add_exp(b, 1'b0);
            dropping = 1;
          end else begin
            add_exp(b, 1'b0);
          end
        end
      end
    end
  endfunction

  task automatic push_pkt(input ent_t p[$]);
    gen_stream(p);
    foreach (p[k]) fq.push_back(p[k]);
  endtask

  task automatic push_rand();
    ent_t p[$];
    ent_t e;
    int n = $urandom_range(1, 6);
    logic [EW-1:0] ep = EW'($urandom);
    logic ty = 1'($urandom);
    for (int k = 0; k < n; k++) begin
      e.eop = (k == n - 1); e.err = 1'($urandom); e.typ = ty; e.dw = 2'($urandom);
      e.endp = ep; e.data = $urandom;
      p.push_back(e);
    end
    push_pkt(p);
  endtask

  task automatic push_lit(input int n, input logic [EW-1:0] ep, input logic ty,
                          input logic [1:0] dw, input logic er);
    ent_t p[$];
    ent_t e;
    for (int k = 0; k < n; k++) begin
      e.eop = (k == n - 1); e.err = (k == n - 1) ? er : 1'b0; e.typ = ty;
      e.dw = dw; e.endp = ep; e.data = 32'h11111111 * (k + 1);
      p.push_back(e);
    end
    push_pkt(p);
  endtask

  task automatic wait_drain(input int budget);
    bit ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk); #2;
      ok = (fq.size() == 0) && (exp_q.size() == 0) && !busy && !bus.pkt_valid;
    end
    chk("drain_done", 64'(ok), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_acc(input int target);
    bit ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk); #2;
      ok = (acc_cnt >= target);
    end
    chk("acc_reached", 64'(ok), 64'd1);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (n) @(negedge clk);
    exp_q.delete();
    exp_bchk.delete();
    reset_n = 1'b1;
    gen_stream(fq);
  endtask

  // FIFO model, sink driver and per-cycle compare process.
  initial begin : drv_mon
    beat_t a;
    beat_t e;
    bit    bc;
    bus.fifo_read_ready = 1'b0; bus.fifo_eop = 1'b0; bus.fifo_error = 1'b0;
    bus.fifo_entry_type = 1'b0; bus.fifo_d_width = 2'd0; bus.fifo_endp_entry = '0;
    bus.fifo_data = '0; bus.pkt_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (pop_pend) begin
        if (fq.size() > 0) fq.delete(0);
        pop_pend = 1'b0;
      end
      if (fq.size() > 0) begin
        bus.fifo_read_ready = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        {bus.fifo_eop, bus.fifo_error, bus.fifo_entry_type, bus.fifo_d_width,
         bus.fifo_endp_entry, bus.fifo_data} = fq[0];
      end else begin
        bus.fifo_read_ready = 1'b0;
        bus.fifo_eop = 1'($urandom); bus.fifo_data = $urandom;
        bus.fifo_endp_entry = EW'($urandom); bus.fifo_d_width = 2'($urandom);
      end
      if (rdy_mode == 0) bus.pkt_ready = 1'b1;
      else if (rdy_mode == 1) bus.pkt_ready = ($urandom_range(0, 2) != 0);
      if (clr_rand) stats_clr = ($urandom_range(0, 15) == 0);
      #1;
      if (was_rst) begin
        chk("reset_state", {bus.pkt_valid, bus.pkt_sop, bus.pkt_eop, bus.pkt_err, bus.pkt_bytes,
                            bus.pkt_data, bus.pkt_endp, busy, pkt_cnt, err_pkt_cnt,
                            bus.fifo_read_command}, 64'd0);
      end
      was_rst = !reset_n;
      chk("rd_gate", 64'(bus.fifo_read_command && !bus.fifo_read_ready), 64'd0);
      if (!reset_n) begin
        exp_pc = 0; exp_ec = 0; hold_vld = 1'b0;
      end else begin
        chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pc));
        chk("err_pkt_cnt", 64'(err_pkt_cnt), 64'(exp_ec));
        if (bus.fifo_read_command) begin
          pop_pend = 1'b1;
          rd_cnt++;
        end
        a = cur_beat();
        if (hold_vld) chk("hold_stable", {bus.pkt_valid, a}, {1'b1, hold_beat});
        if (bus.pkt_valid && bus.pkt_ready) begin
          acc_cnt++;
          acc_log.push_back(a);
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(a), 64'd0);
            n_fail += (a == '0) ? 1 : 0;
          end else begin
            e = exp_q.pop_front();
            bc = exp_bchk.pop_front();
            if (!bc) a.bytes = e.bytes;
            if (!e.eop) a.err = e.err;
            chk("beat", 64'(a), 64'(e));
            if (STATS && e.eop) begin
              if (exp_pc < 65535) exp_pc++;
              if (e.err && exp_ec < 65535) exp_ec++;
            end
          end
        end
        if (stats_clr) begin
          exp_pc = 0; exp_ec = 0;
        end
        hold_vld = bus.pkt_valid && !bus.pkt_ready;
        hold_beat = cur_beat();
      end
    end
  end

  initial begin : main
    int base;
    int rc0;
    int a0;
    bit hit;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drain_en = 1'b1;

    // 3-word packet, eop d_width=2, endp 5, entry_type 1.
    acc_log.delete();
    push_lit(3, 6'd5, 1'b1, 2'd2, 1'b0);
    wait_drain(500);
    chk("a_beats", 64'(acc_log.size()), 64'd4);
    if (acc_log.size() == 4) begin
      chk("a_hdr_data", 64'(acc_log[0].data), 64'h85);
      chk("a_hdr_sop", 64'({acc_log[0].sop, acc_log[0].eop}), 64'b10);
      chk("a_last", 64'({acc_log[3].eop, acc_log[3].bytes, acc_log[3].data}), {31'd0, 3'b110, 32'h33333333});
    end
    chk("a_pkt_cnt", 64'(pkt_cnt), STATS ? 64'd1 : 64'd0);

    // Byte limit 8, 5-word packet: word 3 closes with error, words 4-5 dropped.
    max_len = 12'd8;
    acc_log.delete();
    push_lit(5, 6'd3, 1'b0, 2'd1, 1'b0);
    wait_drain(500);
    chk("b_beats", 64'(acc_log.size()), 64'd4);
    if (acc_log.size() == 4)
      chk("b_last", 64'({acc_log[3].eop, acc_log[3].err, acc_log[3].data}), {30'd0, 2'b11, 32'h33333333});
    chk("b_err_cnt", 64'(err_pkt_cnt), STATS ? 64'd1 : 64'd0);
    max_len = '0;

    // Sink stall of 4 cycles mid-packet.
    rdy_mode = 2;
    bus.pkt_ready = 1'b1;
    acc_log.delete();
    base = acc_cnt;
    push_lit(5, 6'd9, 1'b0, 2'd0, 1'b1);
    wait_acc(base + 2);
    bus.pkt_ready = 1'b0;
    rc0 = rd_cnt; a0 = acc_cnt;
    repeat (4) @(negedge clk);
    chk("c_no_pop", 64'(rd_cnt - rc0), 64'd0);
    chk("c_no_acc", 64'(acc_cnt - a0), 64'd0);
    bus.pkt_ready = 1'b1;
    wait_drain(500);
    chk("c_beats", 64'(acc_log.size()), 64'd6);
    rdy_mode = 0;

    // drain_en dropped mid-packet: packet finishes, next one waits.
    base = acc_cnt;
    push_lit(4, 6'd1, 1'b1, 2'd3, 1'b0);
    push_lit(2, 6'd2, 1'b0, 2'd1, 1'b0);
    wait_acc(base + 2);
    drain_en = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    chk("d_idle", 64'({busy, bus.pkt_valid}), 64'd0);
    chk("d_fifo_left", 64'(fq.size()), 64'd2);
    chk("d_beats", 64'(acc_cnt - base), 64'd5);
    @(negedge clk);
    drain_en = 1'b1;
    wait_drain(500);

    // stats_clr in the same cycle as an accepted eop beat with pkt_cnt=5.
    chk("e_pre_cnt", 64'(pkt_cnt), STATS ? 64'd5 : 64'd0);
    push_lit(2, 6'd7, 1'b0, 2'd2, 1'b0);
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (bus.pkt_valid && bus.pkt_eop) begin
        stats_clr = 1'b1;
        hit = 1;
      end
    end
    chk("e_eop_seen", 64'(hit), 64'd1);
    @(negedge clk);
    stats_clr = 1'b0;
    chk("e_cleared", 64'({pkt_cnt, err_pkt_cnt}), 64'd0);
    wait_drain(500);

    // Randomized traffic under several byte limits.
    rdy_mode = 1;
    clr_rand = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      max_len = (ph == 0) ? 12'd0 : 12'(4 * $urandom_range(2, 6));
      for (int k = 0; k < 25; k++) push_rand();
      wait_drain(20000);
    end

    // Reset in the middle of traffic; the model restarts from the remaining FIFO head.
    for (int k = 0; k < 10; k++) push_rand();
    repeat ($urandom_range(20, 60)) @(negedge clk);
    do_reset(2);
    wait_drain(20000);
    clr_rand = 1'b0;
    stats_clr = 1'b0;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/usbt_pkt_drain.md
USBT_PKT_DRAIN -- requirements
Module: usbt_pkt_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of FIFO data word and output data beat.
REQ-002 SHALL have parameter COD_ENDP_WIDTH, default 6, coded endpoint index width.
REQ-003 SHALL have parameter USB_LEN_WIDTH, default 12, packet byte-length limit width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-005 SHALL have port clk  input  1  single clock for the whole block.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port drain_en  input  1  level enable for starting new packets.
REQ-008 SHALL have port max_usb_pkt_len  input  USB_LEN_WIDTH  payload byte limit; 0 = unlimited.
REQ-009 SHALL have port fifo_read_ready  input  1  FIFO head entry valid (show-ahead).
REQ-010 SHALL have port fifo_read_command  output  1  pop FIFO head this cycle.
REQ-011 SHALL have ports fifo_eop, fifo_error, fifo_entry_type  input  1 each  head entry flags.
REQ-012 SHALL have port fifo_d_width  input  2  valid bytes in eop word: 0=4, 1=1, 2=2, 3=3.
REQ-013 SHALL have ports fifo_endp_entry  input  COD_ENDP_WIDTH  and fifo_data  input  DATA_WIDTH.
REQ-014 SHALL have ports pkt_valid  output  1, pkt_ready  input  1: output valid/ready handshake.
REQ-015 SHALL have ports pkt_sop, pkt_eop, pkt_err  output  1 each  and pkt_bytes  output  2  (d_width encoding).
REQ-016 SHALL have ports pkt_data  output  DATA_WIDTH  and pkt_endp  output  COD_ENDP_WIDTH.
REQ-017 SHALL have ports pkt_cnt, err_pkt_cnt  output  CNT_WIDTH, stats_clr  input  1, busy  output  1.

Function
REQ-018 SHALL implement states IDLE, HDR, DATA, DROP; busy=1 in any state except IDLE.
REQ-019 IDLE->HDR SHALL occur when drain_en=1 and fifo_read_ready=1; head entry is not popped in this transition.
REQ-020 HDR SHALL emit one beat with pkt_sop=1, pkt_eop=0, pkt_endp=head endp, pkt_data={zeros, entry_type, 1'b0, endp}, then go to DATA.
REQ-021 DATA SHALL pop one entry per cycle when fifo_read_ready=1 and the output register is empty or accepted that cycle; popped entry appears on pkt_* the next cycle (latency 1).
REQ-022 Output register SHALL hold pkt_* stable while pkt_valid=1 and pkt_ready=0; no entry is popped then.
REQ-023 Byte counter (USB_LEN_WIDTH+1 bits, saturating) SHALL add 4 per non-eop word, d_width-decoded bytes per eop word; cleared in IDLE.
REQ-024 Entry with fifo_eop=1 in DATA SHALL be emitted with pkt_eop=1, pkt_err=fifo_error, pkt_bytes=fifo_d_width, then go IDLE.
REQ-025 If max_usb_pkt_len!=0 and count after a non-eop word exceeds it, that word SHALL be emitted with pkt_eop=1, pkt_err=1, then go DROP.
REQ-026 DROP SHALL pop entries whenever fifo_read_ready=1 without emitting, and go IDLE after popping the eop entry.
REQ-027 drain_en deassertion SHALL not abort an active packet; only IDLE->HDR is gated.
REQ-028 pkt_cnt SHALL increment on each accepted pkt_eop beat; err_pkt_cnt on each accepted beat with pkt_eop=1 and pkt_err=1; both saturate at all-ones.
REQ-029 stats_clr SHALL zero both counters; an increment in the same cycle is discarded.
REQ-030 fifo_read_command SHALL never assert while fifo_read_ready=0.

Reset
REQ-031 While reset_n=0 at a clk edge: state=IDLE, pkt_valid=0, pkt_sop/eop/err=0, pkt_bytes=0, pkt_data=0, pkt_endp=0, byte counter=0, pkt_cnt=0, err_pkt_cnt=0, busy=0, fifo_read_command=0.
REQ-032 Reset mid-packet SHALL abandon the packet without emitting eop; the next packet starts from the current FIFO head.

Configuration
REQ-033 Macro USBT_PKT_DRAIN_STATS_EN defined: pkt_cnt/err_pkt_cnt counters present per REQ-028/029; undefined: counters removed, both outputs tied to 0, stats_clr ignored.

Verification
REQ-034 Reset, then a 3-word packet (eop on word 3, d_width=2), pkt_ready=1 -> HDR beat then 3 beats; last has pkt_eop=1, pkt_bytes=2; pkt_cnt=1.
REQ-035 max_usb_pkt_len=8, 5-word packet -> word 3 emitted with pkt_eop=1, pkt_err=1; words 4-5 popped silently; err_pkt_cnt=1.
REQ-036 pkt_ready held 0 for 4 cycles mid-packet -> pkt_data stable, fifo_read_command=0 for those cycles, no beat lost or duplicated.
REQ-037 drain_en cleared during word 2 of a 4-word packet -> packet completes; next queued packet not started until drain_en=1.
REQ-038 stats_clr asserted in same cycle as an accepted eop beat with pkt_cnt=5 -> pkt_cnt=0 next cycle.
